xip_prefetch_buf: RTL

XIP_PREFETCH_BUF -- requirements
Module: xip_prefetch_buf

---
 rtl/xip_prefetch_buf.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/xip_prefetch_buf.sv
// xip_prefetch_buf: direct-mapped read prefetch buffer between an AXI-style
// read port (s_*) and an XIP flash engine (m_*). Each line holds four 32-bit
// words; a miss fetches the whole line as four single-beat reads, a hit
// answers one cycle after the address handshake. en_i=0 bypasses the lines
// and forwards a single word fetch.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   en_i, flush_i      cache enable, invalidate all lines
//   s_ar*/s_r*         upstream read address / read data channels
//   m_ar*/m_r*         downstream read address / read data channels
//   hit_o, miss_o      one-cycle event pulses
//   busy_o             high while a transaction is in flight
module xip_prefetch_buf #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINES      = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en_i,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] s_araddr_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [31:0]           s_rdata_o,
    output logic [1:0]            s_rresp_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    output logic [ADDR_WIDTH-1:0] m_araddr_o,
    output logic                  m_arvalid_o,
    input  logic                  m_arready_i,
    input  logic [31:0]           m_rdata_i,
    input  logic [1:0]            m_rresp_i,
    input  logic                  m_rvalid_i,
    output logic                  m_rready_o,
    output logic                  hit_o,
    output logic                  miss_o,
    output logic                  busy_o
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_WIDTH - 4 - IDX_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RESP    = 2'd1;
    localparam logic [1:0] S_FILL_AR = 2'd2;
    localparam logic [1:0] S_FILL_R  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  byp_q, byp_d;
    logic                  flush_seen_q, flush_seen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic [31:0]           rdata_d;
    logic [1:0]            rresp_d;
    logic                  rvalid_d, hit_d, miss_d;
    logic [ADDR_WIDTH-1:0] m_araddr_d;
    logic                  fill_we, commit, commit_valid;

    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [31:0]           data_q [LINES][4];

    // Request address decode
    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic [1:0]       req_word;
    logic             is_hit;

    assign req_word = s_araddr_i[3:2];
    assign req_idx  = s_araddr_i[4 +: IDX_W];
    assign req_tag  = s_araddr_i[ADDR_WIDTH-1 -: TAG_W];
    assign fill_idx = addr_q[4 +: IDX_W];
    assign fill_tag = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign is_hit   = en_i & ~flush_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

    // Byte-offset bits never select anything
    logic unused_ok;
    assign unused_ok = &{1'b0, s_araddr_i[1:0]};

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        byp_d        = byp_q;
        flush_seen_d = flush_seen_q | flush_i;
        addr_d       = addr_q;
        rdata_d      = s_rdata_o;
        rresp_d      = s_rresp_o;
        rvalid_d     = s_rvalid_o;
        hit_d        = 1'b0;
        miss_d       = 1'b0;
        fill_we      = 1'b0;
        commit       = 1'b0;
        m_araddr_d   = m_araddr_o;

        case (state_q)
            S_IDLE: begin
                if (s_arvalid_i && s_arready_o) begin
                    addr_d       = {s_araddr_i[ADDR_WIDTH-1:2], 2'b00};
                    cnt_d        = 2'd0;
                    err_d        = 1'b0;
                    byp_d        = ~en_i;
                    flush_seen_d = 1'b0;
                    if (is_hit) begin
                        rdata_d  = data_q[req_idx][req_word];
                        rresp_d  = 2'b00;
                        rvalid_d = 1'b1;
                        hit_d    = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        miss_d  = 1'b1;
                        state_d = S_FILL_AR;
                    end
                end
            end
            S_FILL_AR: begin
                if (m_arready_i) state_d = S_FILL_R;
            end
            S_FILL_R: begin
                if (m_rvalid_i) begin
                    if (byp_q) begin
                        rdata_d  = m_rdata_i;
                        rresp_d  = m_rresp_i;
                        rvalid_d = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        fill_we = 1'b1;
                        err_d   = err_q | (m_rresp_i != 2'b00);
                        if (cnt_q == addr_q[3:2]) rdata_d = m_rdata_i;
                        if (cnt_q == 2'd3) begin
                            // Last beat: an errored line is never installed
                            commit   = 1'b1;
                            rvalid_d = 1'b1;
                            state_d  = S_RESP;
                            if (err_d) begin
                                rdata_d = 32'd0;
                                rresp_d = 2'b10;
                            end else begin
                                rresp_d = 2'b00;
                            end
                        end else begin
                            cnt_d   = cnt_q + 2'd1;
                            state_d = S_FILL_AR;
                        end
                    end
                end
            end
            default: begin
                if (s_rready_i) begin
                    rvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
        endcase

        if (state_d == S_FILL_AR) begin
            m_araddr_d = byp_d ? addr_d : {addr_d[ADDR_WIDTH-1:4], cnt_d, 2'b00};
        end
    end

    // A flush seen at any point during the fill keeps the line invalid
    assign commit_valid = ~err_d & ~flush_seen_q;

    // State and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            err_q        <= 1'b0;
            byp_q        <= 1'b0;
            flush_seen_q <= 1'b0;
            addr_q       <= '0;
            s_arready_o  <= 1'b0;
            s_rdata_o    <= 32'd0;
            s_rresp_o    <= 2'b00;
            s_rvalid_o   <= 1'b0;
            m_araddr_o   <= '0;
            m_arvalid_o  <= 1'b0;
            m_rready_o   <= 1'b0;
            hit_o        <= 1'b0;
            miss_o       <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            byp_q        <= byp_d;
            flush_seen_q <= flush_seen_d;
            addr_q       <= addr_d;
            s_arready_o  <= (state_d == S_IDLE);
            s_rdata_o    <= rdata_d;
            s_rresp_o    <= rresp_d;
            s_rvalid_o   <= rvalid_d;
            m_araddr_o   <= m_araddr_d;
            m_arvalid_o  <= (state_d == S_FILL_AR);
            m_rready_o   <= (state_d == S_FILL_R);
            hit_o        <= hit_d;
            miss_o       <= miss_d;
            busy_o       <= (state_d != S_IDLE);
        end
    end

    // Line valid bits; flush has priority over a completing fill
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (commit) begin
            valid_q[fill_idx] <= commit_valid;
        end
    end

    // Line data and tags
    always_ff @(posedge clk) begin
        if (fill_we) data_q[fill_idx][cnt_q] <= m_rdata_i;
        if (commit)  tag_q[fill_idx]         <= fill_tag;
    end

endmodule
